// File: rtl/game_seq_if.sv
// Game sequencer bundle: frame tick and buttons in, layer offsets out.
//   frame_tick            one-clk pulse per frame
//   btn_left/btn_right    debounced button levels
//   state                 00 COUNTDOWN, 01 LOGO, 10 HEAD, 11 RUN
//   logo_voffset          logo layer voffset (12-bit signed)
//   head_hoffset          head layer hoffset (12-bit signed)
//   head_voffset          head layer voffset (12-bit signed)
//   coin_loc              coin track position (12-bit signed)
//   coin_wrap             one-clk pulse when coin_loc wraps
// master drives the frame/button side, slave is the sequencer.
interface game_seq_if;
  logic               frame_tick;
  logic               btn_left;
  logic               btn_right;
  logic [1:0]         state;
  logic signed [11:0] logo_voffset;
  logic signed [11:0] head_hoffset;
  logic signed [11:0] head_voffset;
  logic signed [11:0] coin_loc;
  logic               coin_wrap;

  modport master (
    output frame_tick, btn_left, btn_right,
    input  state, logo_voffset, head_hoffset, head_voffset, coin_loc, coin_wrap
  );

  modport slave (
    input  frame_tick, btn_left, btn_right,
    output state, logo_voffset, head_hoffset, head_voffset, coin_loc, coin_wrap
  );
endinterface

// File: rtl/game_sequencer.sv
// Frame-rate game controller for the sprite layer stack.
// Intro: countdown, logo scroll-off, head drop; then play: button-driven
// lane changes with slewed head hoffset and a wrapping coin track.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset, returns every output to its start value
//   io   game_seq_if.slave: frame_tick/btn_left/btn_right in, offsets/state out
module game_sequencer #(
  parameter int COUNTDOWN_FRAMES = 5,
  parameter int LOGO_STEP        = 30,
  parameter int LOGO_END         = 640,
  parameter int HEAD_START       = 180,
  parameter int HEAD_STEP        = 17,
  parameter int HEAD_END         = 50,
  parameter int LANE_PX          = 100,
  parameter int LANE_STEP        = 20,
  parameter int COIN_START       = -50,
  parameter int COIN_MAX         = 100
) (
  input logic       clk,
  input logic       rst,
  game_seq_if.slave io
);

  typedef enum logic [1:0] {
    S_COUNTDOWN = 2'b00,
    S_LOGO      = 2'b01,
    S_HEAD      = 2'b10,
    S_RUN       = 2'b11
  } state_t;

  // 13-bit copies of the limits so every saturation compare sees the
  // sign-extended sum rather than a wrapped 12-bit value.
  localparam logic signed [12:0] LOGO_STEP_X = 13'(LOGO_STEP);
  localparam logic signed [12:0] LOGO_END_X  = 13'(LOGO_END);
  localparam logic signed [12:0] HEAD_STEP_X = 13'(HEAD_STEP);
  localparam logic signed [12:0] HEAD_END_X  = 13'(HEAD_END);
  localparam logic signed [12:0] LANE_STEP_X = 13'(LANE_STEP);
  localparam logic signed [12:0] COIN_MAX_X  = 13'(COIN_MAX);

  state_t             st;
  logic [7:0]         cnt;
  logic signed [11:0] logo_v;
  logic signed [11:0] head_v;
  logic signed [11:0] head_h;
  logic signed [11:0] coin;
  logic               wrap;
  logic signed [1:0]  lane;
  logic               btn_left_p0;
  logic               btn_right_p0;

  logic               edge_l;
  logic               edge_r;
  logic signed [12:0] logo_sum;
  logic signed [12:0] head_sum;
  logic signed [12:0] coin_sum;
  logic signed [11:0] target;

  assign edge_l   = io.btn_left  & ~btn_left_p0;
  assign edge_r   = io.btn_right & ~btn_right_p0;
  assign logo_sum = 13'(logo_v) + LOGO_STEP_X;
  assign head_sum = 13'(head_v) - HEAD_STEP_X;
  assign coin_sum = 13'(coin) + 13'sd1;

  always_comb begin
    target = '0;
    if (lane == 2'sb01)      target = 12'(LANE_PX);
    else if (lane == 2'sb11) target = 12'(-LANE_PX);
  end

  // Move cur toward tgt by at most LANE_STEP, landing exactly on tgt.
  function automatic logic signed [11:0] slew(input logic signed [11:0] cur,
                                              input logic signed [11:0] tgt);
    logic signed [12:0] d;
    d = 13'(tgt) - 13'(cur);
    if (d > LANE_STEP_X)       return 12'(13'(cur) + LANE_STEP_X);
    else if (d < -LANE_STEP_X) return 12'(13'(cur) - LANE_STEP_X);
    else                       return tgt;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_COUNTDOWN;
      cnt          <= 8'(COUNTDOWN_FRAMES);
      logo_v       <= '0;
      head_v       <= 12'(HEAD_START);
      head_h       <= '0;
      coin         <= 12'(COIN_START);
      wrap         <= 1'b0;
      lane         <= '0;
      btn_left_p0  <= 1'b0;
      btn_right_p0 <= 1'b0;
    end else begin
      btn_left_p0  <= io.btn_left;
      btn_right_p0 <= io.btn_right;
      wrap         <= 1'b0;

      // Lane edges act every clk in RUN; simultaneous edges cancel. The slew
      // below reads the old lane, so a coinciding tick still uses the old target.
      if (st == S_RUN && (edge_l ^ edge_r)) begin
        if (edge_l && lane != 2'sb11)      lane <= lane - 2'sd1;
        else if (edge_r && lane != 2'sb01) lane <= lane + 2'sd1;
      end

      if (io.frame_tick) begin
        unique case (st)
          S_COUNTDOWN: begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) st <= S_LOGO;
          end
          S_LOGO: begin
            if (logo_sum >= LOGO_END_X) begin
              logo_v <= 12'(LOGO_END);
              st     <= S_HEAD;
            end else begin
              logo_v <= 12'(logo_sum);
            end
          end
          S_HEAD: begin
            if (head_sum <= HEAD_END_X) begin
              head_v <= 12'(HEAD_END);
              st     <= S_RUN;
            end else begin
              head_v <= 12'(head_sum);
            end
          end
          S_RUN: begin
            head_h <= slew(head_h, target);
            if (coin < 0) begin
              coin <= '0;
            end else if (coin_sum >= COIN_MAX_X) begin
              coin <= '0;
              wrap <= 1'b1;
            end else begin
              coin <= 12'(coin_sum);
            end
          end
          default: st <= S_COUNTDOWN;
        endcase
      end
    end
  end

  assign io.state        = st;
  assign io.logo_voffset = logo_v;
  assign io.head_hoffset = head_h;
  assign io.head_voffset = head_v;
  assign io.coin_loc     = coin;
  assign io.coin_wrap    = wrap;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: table-driven intro/coin vectors plus
// hand-written lane, reset and countdown-press sequences.
module tb_game_sequencer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  game_seq_if io ();

  game_sequencer dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ticks;
    int state;
    int logo;
    int head_v;
    int head_h;
    int coin;
    int wrap;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int s, input int lv, input int hv,
                         input int hh, input int c, input int w);
    chk({nm, ".state"}, int'(io.state), s);
    chk({nm, ".logo"},  int'($signed(io.logo_voffset)), lv);
    chk({nm, ".headv"}, int'($signed(io.head_voffset)), hv);
    chk({nm, ".headh"}, int'($signed(io.head_hoffset)), hh);
    chk({nm, ".coin"},  int'($signed(io.coin_loc)), c);
    chk({nm, ".wrap"},  int'(io.coin_wrap), w);
  endtask

  // Called at a negedge; returns at the next negedge after the tick edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      io.frame_tick = 1'b1;
      @(negedge clk);
      io.frame_tick = 1'b0;
    end
  endtask

  task automatic press(input logic l, input logic r);
    io.btn_left  = l;
    io.btn_right = r;
    repeat (3) @(negedge clk);
    io.btn_left  = 1'b0;
    io.btn_right = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    io.frame_tick = 1'b0;
    io.btn_left   = 1'b0;
    io.btn_right  = 1'b0;
    rst = 1'b1;

    //            ticks st logo  hv  hh  coin wrap
    vecs[0] = '{4,  0,   0, 180, 0, -50, 0};
    vecs[1] = '{1,  1,   0, 180, 0, -50, 0};
    vecs[2] = '{21, 1, 630, 180, 0, -50, 0};
    vecs[3] = '{1,  2, 640, 180, 0, -50, 0};
    vecs[4] = '{7,  2, 640,  61, 0, -50, 0};
    vecs[5] = '{1,  3, 640,  50, 0, -50, 0};
    vecs[6] = '{1,  3, 640,  50, 0,   0, 0};
    vecs[7] = '{99, 3, 640,  50, 0,  99, 0};
    vecs[8] = '{1,  3, 640,  50, 0,   0, 1};

    #1;
    chk_all("reset", 0, 0, 180, 0, -50, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Button presses during countdown must be discarded.
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);

    for (int v = 0; v < 9; v++) begin
      tick(vecs[v].ticks);
      chk_all($sformatf("vec%0d", v), vecs[v].state, vecs[v].logo, vecs[v].head_v,
              vecs[v].head_h, vecs[v].coin, vecs[v].wrap);
    end
    @(negedge clk);
    chk("wrap_pulse_end", int'(io.coin_wrap), 0);

    // Right lane: slew 20 per tick up to 100.
    press(1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk($sformatf("slew_r%0d", k), int'($signed(io.head_hoffset)), 20 * k);
    end
    press(1'b0, 1'b1);
    tick(2);
    chk("right_sat", int'($signed(io.head_hoffset)), 100);

    // Two lefts: 100 down to -100.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk($sformatf("slew_l%0d", k), int'($signed(io.head_hoffset)), 100 - 20 * k);
    end
    tick(1);
    chk("left_hold", int'($signed(io.head_hoffset)), -100);

    // Held right moves one lane only; simultaneous left+right is ignored.
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk($sformatf("slew_c%0d", k), int'($signed(io.head_hoffset)), -100 + 20 * k);
    end
    tick(1);
    chk("center_hold", int'($signed(io.head_hoffset)), 0);

    // Async reset between clock edges, with a tick held during reset.
    #2;
    rst = 1'b1;
    io.frame_tick = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 180, 0, -50, 0);
    @(negedge clk);
    chk_all("rst_tick_ignored", 0, 0, 180, 0, -50, 0);
    io.frame_tick = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    press(1'b0, 1'b1);
    tick(4);
    chk("cd_after4", int'(io.state), 0);
    tick(1);
    chk("cd_after5", int'(io.state), 1);
    tick(22);
    chk("logo_done", int'(io.state), 2);
    tick(8);
    chk("head_done", int'(io.state), 3);
    tick(3);
    chk("cd_press_ignored", int'($signed(io.head_hoffset)), 0);
    chk("coin_after3", int'($signed(io.coin_loc)), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
